// File: rtl/sram_port_arbiter.sv
// Two-requester round-robin arbiter in front of a single SRAM controller port.
// One transaction at a time: IDLE -> BUSY (registered command) -> DONE (ack pulse) -> IDLE.
// A watchdog aborts a BUSY transaction that the controller never completes.
module sram_port_arbiter #(
    parameter int unsigned AW      = 32,
    parameter int unsigned DW      = 32,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic          clk,
    input  logic          rst,
    // Port 0 (MEM stage)
    input  logic          p0_req,
    input  logic          p0_we,
    input  logic [AW-1:0] p0_addr,
    input  logic [DW-1:0] p0_wdata,
    output logic          p0_ack,
    output logic [DW-1:0] p0_rdata,
    // Port 1 (secondary master)
    input  logic          p1_req,
    input  logic          p1_we,
    input  logic [AW-1:0] p1_addr,
    input  logic [DW-1:0] p1_wdata,
    output logic          p1_ack,
    output logic [DW-1:0] p1_rdata,
    // SRAM controller command port
    output logic          ctrl_w_en,
    output logic          ctrl_r_en,
    output logic [AW-1:0] ctrl_addr,
    output logic [DW-1:0] ctrl_wdata,
    input  logic [DW-1:0] ctrl_rdata,
    input  logic          ctrl_ready,
    // Status
    output logic [1:0]    grant,
    output logic          busy,
    output logic          err_timeout
);

    // Watchdog width; a disabled watchdog still keeps a 1-bit counter to stay legal.
    localparam int unsigned   CW      = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam bit            WdogOn  = (TIMEOUT > 0);
    localparam logic [CW-1:0] TermCnt = WdogOn ? CW'(TIMEOUT - 1) : '0;
    localparam logic [CW-1:0] MaxCnt  = '1;

    typedef enum logic [1:0] {
        StIdle,
        StBusy,
        StDone
    } state_e;

    state_e        state_q, state_d;
    logic          last_q, last_d;           // 1 = port 1 owned the last grant
    logic          ctrl_w_en_q, ctrl_w_en_d;
    logic          ctrl_r_en_q, ctrl_r_en_d;
    logic [AW-1:0] ctrl_addr_q, ctrl_addr_d;
    logic [DW-1:0] ctrl_wdata_q, ctrl_wdata_d;
    logic [1:0]    grant_q, grant_d;
    logic          busy_q, busy_d;
    logic          p0_ack_q, p0_ack_d;
    logic          p1_ack_q, p1_ack_d;
    logic [DW-1:0] p0_rdata_q, p0_rdata_d;
    logic [DW-1:0] p1_rdata_q, p1_rdata_d;
    logic          err_q, err_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic          win1;
    logic          wd_hit;
    logic [DW-1:0] rd_val;

    // Next-state: arbitration in IDLE, completion/abort in BUSY, single-cycle DONE.
    always_comb begin
        state_d      = state_q;
        last_d       = last_q;
        ctrl_w_en_d  = ctrl_w_en_q;
        ctrl_r_en_d  = ctrl_r_en_q;
        ctrl_addr_d  = ctrl_addr_q;
        ctrl_wdata_d = ctrl_wdata_q;
        grant_d      = grant_q;
        busy_d       = busy_q;
        p0_ack_d     = 1'b0;
        p1_ack_d     = 1'b0;
        p0_rdata_d   = p0_rdata_q;
        p1_rdata_d   = p1_rdata_q;
        err_d        = err_q;
        cnt_d        = cnt_q;
        win1         = 1'b0;
        wd_hit       = 1'b0;
        rd_val       = '0;

        case (state_q)
            StIdle: begin
                if (p0_req || p1_req) begin
                    // On a tie the port that did not win last time gets the grant.
                    win1         = p1_req && (!p0_req || !last_q);
                    ctrl_addr_d  = win1 ? p1_addr  : p0_addr;
                    ctrl_wdata_d = win1 ? p1_wdata : p0_wdata;
                    ctrl_w_en_d  = win1 ? p1_we    : p0_we;
                    ctrl_r_en_d  = win1 ? !p1_we   : !p0_we;
                    grant_d      = win1 ? 2'b10    : 2'b01;
                    last_d       = win1;
                    cnt_d        = '0;
                    busy_d       = 1'b1;
                    state_d      = StBusy;
                end
            end
            StBusy: begin
                if (cnt_q != MaxCnt) begin
                    cnt_d = cnt_q + CW'(1);
                end
                wd_hit = WdogOn && (cnt_q == TermCnt);
                // Completion takes priority over a watchdog hit in the same cycle.
                if (ctrl_ready || wd_hit) begin
                    rd_val      = ctrl_ready ? ctrl_rdata : '0;
                    ctrl_w_en_d = 1'b0;
                    ctrl_r_en_d = 1'b0;
                    grant_d     = 2'b00;
                    p0_ack_d    = grant_q[0];
                    p1_ack_d    = grant_q[1];
                    if (ctrl_r_en_q && grant_q[0]) begin
                        p0_rdata_d = rd_val;
                    end
                    if (ctrl_r_en_q && grant_q[1]) begin
                        p1_rdata_d = rd_val;
                    end
                    if (!ctrl_ready) begin
                        err_d = 1'b1;
                    end
                    state_d = StDone;
                end
            end
            StDone: begin
                busy_d  = 1'b0;
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and output registers; reset drops any in-flight command immediately.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= StIdle;
            last_q       <= 1'b1;
            ctrl_w_en_q  <= 1'b0;
            ctrl_r_en_q  <= 1'b0;
            ctrl_addr_q  <= '0;
            ctrl_wdata_q <= '0;
            grant_q      <= 2'b00;
            busy_q       <= 1'b0;
            p0_ack_q     <= 1'b0;
            p1_ack_q     <= 1'b0;
            p0_rdata_q   <= '0;
            p1_rdata_q   <= '0;
            err_q        <= 1'b0;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            last_q       <= last_d;
            ctrl_w_en_q  <= ctrl_w_en_d;
            ctrl_r_en_q  <= ctrl_r_en_d;
            ctrl_addr_q  <= ctrl_addr_d;
            ctrl_wdata_q <= ctrl_wdata_d;
            grant_q      <= grant_d;
            busy_q       <= busy_d;
            p0_ack_q     <= p0_ack_d;
            p1_ack_q     <= p1_ack_d;
            p0_rdata_q   <= p0_rdata_d;
            p1_rdata_q   <= p1_rdata_d;
            err_q        <= err_d;
            cnt_q        <= cnt_d;
        end
    end

    assign ctrl_w_en   = ctrl_w_en_q;
    assign ctrl_r_en   = ctrl_r_en_q;
    assign ctrl_addr   = ctrl_addr_q;
    assign ctrl_wdata  = ctrl_wdata_q;
    assign grant       = grant_q;
    assign busy        = busy_q;
    assign p0_ack      = p0_ack_q;
    assign p1_ack      = p1_ack_q;
    assign p0_rdata    = p0_rdata_q;
    assign p1_rdata    = p1_rdata_q;
    assign err_timeout = err_q;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Bench for sram_port_arbiter: directed scenarios with literal expectations, then
// randomized traffic checked every cycle against a transaction-level model.
module tb_sram_port_arbiter;

    localparam int unsigned TO = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_v   [2];
    logic        we_v    [2];
    logic [31:0] addr_v  [2];
    logic [31:0] wdata_v [2];
    logic        p0_req, p0_we, p1_req, p1_we;
    logic [31:0] p0_addr, p0_wdata, p1_addr, p1_wdata;
    logic        p0_ack, p1_ack;
    logic [31:0] p0_rdata, p1_rdata;
    logic        ctrl_w_en, ctrl_r_en, ctrl_ready;
    logic [31:0] ctrl_addr, ctrl_wdata, ctrl_rdata;
    logic [1:0]  grant;
    logic        busy, err_timeout;

    assign p0_req   = req_v[0];
    assign p0_we    = we_v[0];
    assign p0_addr  = addr_v[0];
    assign p0_wdata = wdata_v[0];
    assign p1_req   = req_v[1];
    assign p1_we    = we_v[1];
    assign p1_addr  = addr_v[1];
    assign p1_wdata = wdata_v[1];

    sram_port_arbiter #(
        .AW      (32),
        .DW      (32),
        .TIMEOUT (TO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .p0_req      (p0_req),
        .p0_we       (p0_we),
        .p0_addr     (p0_addr),
        .p0_wdata    (p0_wdata),
        .p0_ack      (p0_ack),
        .p0_rdata    (p0_rdata),
        .p1_req      (p1_req),
        .p1_we       (p1_we),
        .p1_addr     (p1_addr),
        .p1_wdata    (p1_wdata),
        .p1_ack      (p1_ack),
        .p1_rdata    (p1_rdata),
        .ctrl_w_en   (ctrl_w_en),
        .ctrl_r_en   (ctrl_r_en),
        .ctrl_addr   (ctrl_addr),
        .ctrl_wdata  (ctrl_wdata),
        .ctrl_rdata  (ctrl_rdata),
        .ctrl_ready  (ctrl_ready),
        .grant       (grant),
        .busy        (busy),
        .err_timeout (err_timeout)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;
    bit stop_cmp = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Transaction-level model: at most one open transaction, plus a one-cycle ack window.
    bit          m_txn, m_done, m_we, m_err;
    int          m_owner, m_last, m_g, cyc;
    logic [31:0] m_addr, m_wdata;
    logic [31:0] m_rdata [2];

    task automatic model_reset();
        m_txn = 0; m_done = 0; m_we = 0; m_err = 0;
        m_owner = 0; m_last = 1; m_g = 0; cyc = 0;
        m_addr = '0; m_wdata = '0;
        m_rdata[0] = '0; m_rdata[1] = '0;
    endtask

    task automatic model_step();
        cyc++;
        if (m_done) begin
            m_done = 0;
        end else if (m_txn) begin
            // Abort lands its ack TO+1 cycles after the grant edge.
            if (ctrl_ready || (TO != 0 && cyc - m_g == int'(TO))) begin
                if (!m_we) m_rdata[m_owner] = ctrl_ready ? ctrl_rdata : 32'h0;
                if (!ctrl_ready) m_err = 1;
                m_txn  = 0;
                m_done = 1;
            end
        end else if (req_v[0] || req_v[1]) begin
            if (req_v[0] && req_v[1]) m_owner = 1 - m_last;
            else m_owner = req_v[1] ? 1 : 0;
            m_last  = m_owner;
            m_we    = we_v[m_owner];
            m_addr  = addr_v[m_owner];
            m_wdata = wdata_v[m_owner];
            m_txn   = 1;
            m_g     = cyc;
        end
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst);
            if (!rst) model_reset();
            else model_step();
        end
    end

    // Per-cycle comparison of every output against the model.
    initial begin
        logic [1:0] eg, ea;
        forever begin
            @(negedge clk);
            if (!stop_cmp) begin
                eg = m_txn ? ((m_owner == 1) ? 2'b10 : 2'b01) : 2'b00;
                ea = m_done ? ((m_owner == 1) ? 2'b10 : 2'b01) : 2'b00;
                check("m_w_en",   64'(ctrl_w_en),  64'(m_txn && m_we));
                check("m_r_en",   64'(ctrl_r_en),  64'(m_txn && !m_we));
                check("m_addr",   64'(ctrl_addr),  64'(m_addr));
                check("m_wdata",  64'(ctrl_wdata), 64'(m_wdata));
                check("m_grant",  64'(grant),      64'(eg));
                check("m_busy",   64'(busy),       64'(m_txn || m_done));
                check("m_ack",    64'({p1_ack, p0_ack}), 64'(ea));
                check("m_rdata0", 64'(p0_rdata),   64'(m_rdata[0]));
                check("m_rdata1", 64'(p1_rdata),   64'(m_rdata[1]));
                check("m_err",    64'(err_timeout), 64'(m_err));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic start_req(input int p, input logic we, input logic [31:0] a,
                             input logic [31:0] d);
        req_v[p] = 1'b1; we_v[p] = we; addr_v[p] = a; wdata_v[p] = d;
    endtask

    logic [1:0] exp_order [4];
    logic [1:0] gseq [4];
    int         gcyc [4];
    int         acyc [4];
    int         ng, na;
    logic [1:0] prevg;

    initial begin
        rst = 1'b0;
        ctrl_ready = 1'b0;
        ctrl_rdata = '0;
        for (int p = 0; p < 2; p++) begin
            req_v[p] = 1'b0; we_v[p] = 1'b0; addr_v[p] = '0; wdata_v[p] = '0;
        end
        exp_order[0] = 2'b01; exp_order[1] = 2'b10;
        exp_order[2] = 2'b01; exp_order[3] = 2'b10;
        ticks(2);
        rst = 1'b1;
        tick();
        check("rst_grant", 64'(grant), 64'(2'b00));
        check("rst_busy",  64'(busy), 64'(0));
        check("rst_cmd",   64'({ctrl_w_en, ctrl_r_en}), 64'(0));
        check("rst_addr",  64'(ctrl_addr), 64'(0));
        check("rst_rdata", 64'({p0_rdata, p1_rdata}), 64'(0));
        check("rst_err",   64'(err_timeout), 64'(0));

        // Port 0 read, controller ready in cycle 5.
        start_req(0, 1'b0, 32'h400, 32'h0);
        tick();
        check("t1_r_en_c1", 64'(ctrl_r_en), 64'(1));
        check("t1_grant_c1", 64'(grant), 64'(2'b01));
        check("t1_addr", 64'(ctrl_addr), 64'(32'h400));
        ticks(4);
        check("t1_r_en_c5", 64'(ctrl_r_en), 64'(1));
        ctrl_ready = 1'b1; ctrl_rdata = 32'hDEADBEEF;
        tick();
        ctrl_ready = 1'b0; ctrl_rdata = '0;
        check("t1_ack", 64'(p0_ack), 64'(1));
        check("t1_rdata", 64'(p0_rdata), 64'(32'hDEADBEEF));
        check("t1_r_en_c6", 64'(ctrl_r_en), 64'(0));
        req_v[0] = 1'b0;
        tick();
        check("t1_ack_drop", 64'(p0_ack), 64'(0));

        // Port 1 write.
        start_req(1, 1'b1, 32'h404, 32'h12345678);
        tick();
        check("t2_w_en", 64'({ctrl_w_en, ctrl_r_en}), 64'(2'b10));
        check("t2_addr", 64'(ctrl_addr), 64'(32'h404));
        check("t2_wdata", 64'(ctrl_wdata), 64'(32'h12345678));
        check("t2_grant", 64'(grant), 64'(2'b10));
        tick();
        ctrl_ready = 1'b1; ctrl_rdata = 32'h55AA55AA;
        tick();
        ctrl_ready = 1'b0;
        check("t2_ack", 64'(p1_ack), 64'(1));
        check("t2_rdata", 64'(p1_rdata), 64'(0));
        req_v[1] = 1'b0;
        tick();
        check("t2_ack_once", 64'(p1_ack), 64'(0));
        tick();

        // Both ports requesting continuously; controller always ready.
        start_req(0, 1'b0, 32'h100, 32'h0);
        start_req(1, 1'b0, 32'h200, 32'h0);
        ctrl_ready = 1'b1;
        ng = 0; na = 0; prevg = 2'b00;
        for (int c = 0; c < 40 && na < 4; c++) begin
            ctrl_rdata = $urandom;
            tick();
            if (grant != 2'b00 && prevg == 2'b00 && ng < 4) begin
                gseq[ng] = grant; gcyc[ng] = c; ng++;
                if (ng == 4) begin req_v[0] = 1'b0; req_v[1] = 1'b0; end
            end
            if ((p0_ack || p1_ack) && na < 4) begin acyc[na] = c; na++; end
            prevg = grant;
        end
        ctrl_ready = 1'b0;
        check("t3_ngrants", 64'(ng), 64'(4));
        check("t3_nacks", 64'(na), 64'(4));
        for (int i = 0; i < 4; i++) begin
            if (i < ng) check($sformatf("t3_order%0d", i), 64'(gseq[i]), 64'(exp_order[i]));
        end
        for (int i = 0; i < 3; i++) begin
            if (i + 1 < ng && i < na) check("t3_gap", 64'(gcyc[i+1] - acyc[i]), 64'(2));
        end
        ticks(2);

        // Ready on the watchdog terminal-count cycle: normal completion.
        rst = 1'b0;
        tick();
        rst = 1'b1;
        start_req(0, 1'b0, 32'h800, 32'h0);
        tick();
        ticks(TO - 1);
        ctrl_ready = 1'b1; ctrl_rdata = 32'hCAFEF00D;
        tick();
        ctrl_ready = 1'b0;
        check("t5_ack", 64'(p0_ack), 64'(1));
        check("t5_rdata", 64'(p0_rdata), 64'(32'hCAFEF00D));
        check("t5_err", 64'(err_timeout), 64'(0));
        req_v[0] = 1'b0;
        ticks(2);

        // Controller never ready: abort with ack at cycle TO+1.
        start_req(0, 1'b0, 32'h808, 32'h0);
        tick();
        ticks(TO - 1);
        check("t4_no_ack_early", 64'(p0_ack), 64'(0));
        tick();
        check("t4_ack", 64'(p0_ack), 64'(1));
        check("t4_rdata", 64'(p0_rdata), 64'(0));
        check("t4_err", 64'(err_timeout), 64'(1));
        req_v[0] = 1'b0;
        ticks(2);
        start_req(1, 1'b1, 32'h900, 32'h77);
        tick();
        ctrl_ready = 1'b1;
        tick();
        ctrl_ready = 1'b0;
        check("t4_next_ack", 64'(p1_ack), 64'(1));
        check("t4_err_sticky", 64'(err_timeout), 64'(1));
        req_v[1] = 1'b0;
        ticks(2);

        // Asynchronous reset in BUSY.
        start_req(1, 1'b0, 32'hA00, 32'h0);
        tick();
        check("t6_busy", 64'(busy), 64'(1));
        #2;
        rst = 1'b0;
        #1;
        check("t6_cmd", 64'({ctrl_w_en, ctrl_r_en}), 64'(0));
        check("t6_grant", 64'(grant), 64'(0));
        check("t6_busy0", 64'(busy), 64'(0));
        check("t6_acks", 64'({p0_ack, p1_ack}), 64'(0));
        check("t6_err", 64'(err_timeout), 64'(0));
        req_v[1] = 1'b0;
        tick();
        rst = 1'b1;
        ctrl_ready = 1'b1;
        ticks(2);
        check("t6_spurious", 64'({p0_ack, p1_ack, busy}), 64'(0));
        ctrl_ready = 1'b0;
        tick();

        // Randomized traffic, checked every cycle by the model.
        for (int c = 0; c < 3000; c++) begin
            for (int p = 0; p < 2; p++) begin
                if (req_v[p] && ((p == 0) ? p0_ack : p1_ack)) begin
                    req_v[p] = 1'b0;
                end else if (!req_v[p]) begin
                    if ($urandom_range(2) == 0) start_req(p, 1'($urandom), $urandom, $urandom);
                end else if (!grant[p]) begin
                    if ($urandom_range(19) == 0) req_v[p] = 1'b0;
                end else if ($urandom_range(3) == 0) begin
                    addr_v[p] = $urandom; wdata_v[p] = $urandom; we_v[p] = 1'($urandom);
                end
            end
            ctrl_ready = (c < 1500) ? ($urandom_range(3) == 0) : ($urandom_range(1) == 0);
            ctrl_rdata = $urandom;
            tick();
        end

        stop_cmp = 1'b1;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/sram_port_arbiter.md
# sram_port_arbiter

Two-requester arbiter that shares the single SRAM controller port behind `DataMemory` between the MEM stage (port 0) and a secondary master such as a program loader or debug DMA (port 1). It runs one transaction at a time with round-robin fairness, registers the winning command toward the controller, and returns read data with a one-cycle acknowledge. A timeout watchdog flags a controller that never completes.

## Interface

Parameters:
- AW, 32: address width.
- DW, 32: data width.
- TIMEOUT, 64: maximum cycles in BUSY before the transaction is aborted. 0 disables the watchdog.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  reset, asynchronous, active-low.
- p0_req  input  1  port 0 request level; held until p0_ack.
- p0_we  input  1  port 0 direction: 1 = write, 0 = read.
- p0_addr  input  AW  port 0 byte address.
- p0_wdata  input  DW  port 0 write data.
- p0_ack  output  1  one-cycle completion pulse for port 0.
- p0_rdata  output  DW  port 0 read data; valid while p0_ack is high, held until the next port 0 completion.
- p1_req, p1_we, p1_addr, p1_wdata, p1_ack, p1_rdata: identical to port 0, for port 1.
- ctrl_w_en  output  1  write command to the SRAM controller.
- ctrl_r_en  output  1  read command to the SRAM controller.
- ctrl_addr  output  AW  registered command address.
- ctrl_wdata  output  DW  registered command write data.
- ctrl_rdata  input  DW  controller read data; valid when ctrl_ready=1.
- ctrl_ready  input  1  controller completion; a high level in BUSY ends the transaction.
- grant  output  2  one-hot current owner; 00 when no transaction is active.
- busy  output  1  high in BUSY and DONE.
- err_timeout  output  1  sticky watchdog flag; cleared only by rst.

## Operation

- States: IDLE, BUSY, DONE.
- IDLE:
  - Samples p0_req and p1_req.
  - If neither is high, the arbiter stays in IDLE.
  - If exactly one is high, that port wins.
  - If both are high, the port other than last_grant wins.
  - On the grant edge, the arbiter latches the winner's addr, wdata and we into the ctrl_* registers, sets ctrl_w_en = we and ctrl_r_en = ~we, sets grant one-hot, updates last_grant, clears the watchdog counter, and moves to BUSY.
- BUSY:
  - ctrl_* outputs are held constant.
  - Requester input changes after the grant are ignored.
  - When ctrl_ready=1, the arbiter captures ctrl_rdata into the owner's rdata register (reads only; writes leave rdata unchanged), deasserts ctrl_w_en, ctrl_r_en and grant, pulses the owner's ack, and moves to DONE.
  - If the watchdog counter reaches TIMEOUT-1 while ctrl_ready=0, the arbiter aborts: it deasserts the command, pulses ack, loads rdata with 0 for a read, sets err_timeout, and moves to DONE.
- DONE:
  - Lasts exactly one cycle; ack is high in this cycle and no grant is made.
  - The state then returns to IDLE, which gives the controller a one-cycle command gap.
  - Requesters deassert req in response to ack; a req still high in the following IDLE cycle starts a new transaction.
- Arithmetic and width rules:
  - The watchdog counter is $clog2(TIMEOUT+1) bits wide and saturates.
  - Addresses and data pass through without modification.
- Boundary conditions:
  - ctrl_ready and the watchdog terminal count in the same cycle: completion wins, err_timeout is not set.
  - ctrl_ready high in IDLE or DONE: ignored, no ack.
  - req withdrawn before the grant: no transaction. req withdrawn after the grant: the transaction completes and ack still pulses.
  - Reset mid-transaction: immediate return to IDLE and all outputs to reset values; the controller sees its command dropped.

## Timing

- Reset values:
  - state = IDLE, last_grant = port 1 (so port 0 wins the first tie).
  - ctrl_w_en = 0, ctrl_r_en = 0, ctrl_addr = 0, ctrl_wdata = 0.
  - grant = 00, busy = 0, p0_ack = 0, p1_ack = 0, p0_rdata = 0, p1_rdata = 0, err_timeout = 0.
- All outputs are registered.
- Cycle-level sequence:
  - req is sampled in IDLE at edge 0.
  - The command is visible from cycle 1.
  - If the controller raises ctrl_ready in cycle k, ack and rdata appear in cycle k+1 (DONE).
  - IDLE is at cycle k+2.
- Minimum issue interval: controller latency + 2 cycles.
- Abort timing: ack arrives TIMEOUT+1 cycles after the grant edge.
- Starvation bound: with both ports requesting continuously, grants alternate 0,1,0,1.

## Test plan

- Port 0 read of addr 0x400, controller ready after 5 cycles with rdata 0xDEADBEEF -> ctrl_r_en=1 for cycles 1-5, p0_ack in cycle 6, p0_rdata=0xDEADBEEF, grant=01 in cycles 1-5.
- Port 1 write of addr 0x404, data 0x12345678 -> ctrl_w_en=1, ctrl_addr=0x404, ctrl_wdata=0x12345678; after ready, p1_ack pulses once and p1_rdata is unchanged.
- Both ports requesting continuously from reset, four transactions -> grant order 01,10,01,10, with exactly one IDLE cycle between the DONE of one transaction and the next command.
- TIMEOUT=8 with ctrl_ready held 0 -> ack at cycle 9, rdata=0, err_timeout=1 and sticky; the next transaction completes normally with err_timeout still 1.
- ctrl_ready asserted on the terminal-count cycle -> normal completion, err_timeout=0.
- rst pulsed low in BUSY -> ctrl_r_en, ctrl_w_en, grant, busy and ack all 0 asynchronously; a spurious ctrl_ready after reset produces no ack.
